imem_access_arbiter: RTL and testbench
======================================

// Module: imem_access_arbiter
//
// PURPOSE
//   Sequences and shares the byte-wide, synchronous-read instruction memory
//   between two requesters: the core fetch port and the program loader.
//   The loader uses a UART/debug path and writes one byte per access.
//   The block enforces the memory's 1-cycle read latency, holds the core in
//   stall while programming, and counts bytes loaded. It sits between the
//   core/loader and the instruction memory.
//
// PARAMETERS
//   ADDR_W   11   byte-address width of memory (2^ADDR_W bytes, 2048 default)
//
// PORTS
//   clk         in   1       system clock, all state on rising edge
//   rst         in   1       asynchronous reset, active-high
//   prog_mode   in   1       1 = loader owns memory, core stalled
//   f_req       in   1       fetch request, held until f_gnt
//   f_addr      in   32      fetch byte address (bits [1:0] ignored)
//   f_gnt       out  1       fetch accepted this cycle (combinational)
//   f_valid     out  1       1-cycle pulse: f_instr holds fetched word
//   f_instr     out  32      fetched instruction, registered, held until next
//   f_err       out  1       1-cycle pulse: fetch address out of range
//   l_req       in   1       loader byte-write request, held until l_gnt
//   l_addr      in   32      loader byte address
//   l_data      in   8       loader byte
//   l_gnt       out  1       loader write accepted this cycle (combinational)
//   m_re        out  1       memory read strobe
//   m_we        out  1       memory byte write strobe
//   m_addr      out  ADDR_W  memory byte address (word-aligned on reads)
//   m_wdata     out  8       memory write byte
//   m_rdata     in   32      memory read word, valid 1 cycle after m_re
//   core_stall  out  1       = prog_mode | (fetch in flight)
//   load_count  out  ADDR_W+1  bytes written since prog_mode rose
//
// BEHAVIOUR
//   - Reset values: state IDLE; f_gnt/f_valid/f_err/l_gnt/m_re/m_we = 0.
//     f_instr = 32'h00000013 (NOP). load_count = 0. m_addr/m_wdata = 0.
//     core_stall = prog_mode.
//   - FSM states IDLE, RD_WAIT, RD_CAP.
//   - IDLE, prog_mode=1: l_req -> l_gnt, m_we, m_addr=l_addr[ADDR_W-1:0],
//     m_wdata=l_data, same cycle; stay IDLE. f_req is ignored (no f_gnt).
//   - IDLE, prog_mode=0: f_req has priority over l_req.
//     - In-range fetch: f_gnt, m_re, m_addr={f_addr[ADDR_W-1:2],2'b00};
//       go to RD_WAIT.
//     - Out-of-range fetch (f_addr[31:ADDR_W]!=0): f_gnt, no m_re,
//       f_err pulses next cycle; stay IDLE.
//     - If no f_req, l_req is served as in prog_mode=1.
//   - RD_WAIT: no grants; memory returns word -> RD_CAP.
//   - RD_CAP: f_instr <= m_rdata; go to IDLE. f_valid is high the cycle
//     after RD_CAP. Latency: f_gnt edge to f_valid = 2 cycles.
//     Back-to-back fetches: next f_gnt no earlier than the f_valid cycle.
//   - Loader out-of-range address: l_gnt asserted, m_we suppressed,
//     load_count not incremented.
//   - load_count: cleared on prog_mode rising edge; +1 per in-range write.
//     Saturates at 2^ADDR_W.
//   - prog_mode rising during RD_WAIT/RD_CAP: fetch completes, f_valid
//     still fires. Loader grants wait until IDLE.
//   - Simultaneous m_re and m_we never occur.
//   - Reset mid-access: in-flight fetch dropped, no f_valid after reset.
//   - Byte order to memory is little-endian; writes use byte addresses.
//
// TESTING
//   1. Reset, prog_mode=1, write bytes 13,00,00,00 at addr 0..3.
//      -> 4 l_gnt, m_we each cycle, load_count=4.
//   2. prog_mode=0, f_req addr 0x2 with m_rdata model.
//      -> m_addr=0; f_valid 2 cycles after f_gnt; f_instr=0x00000013.
//   3. f_req and l_req same cycle, prog_mode=0.
//      -> fetch granted first; l_gnt in the f_valid (IDLE) cycle.
//   4. f_req addr 0x800 (ADDR_W=11) -> f_gnt, no m_re, f_err pulse next cycle.
//   5. prog_mode=1, f_req held 10 cycles -> no f_gnt, core_stall=1.
//      l_addr 0x900 -> l_gnt, no m_we, count unchanged.
//   6. Assert rst in RD_WAIT -> all outputs at reset values, no later f_valid.

Source files
------------

// File: rtl/imem_access_arbiter.sv
// Shares a byte-wide, synchronous-read instruction memory between the core
// fetch port and the program loader; tracks bytes loaded per programming session.
module imem_access_arbiter #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_mode,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_gnt,
  output logic              f_valid,
  output logic [31:0]       f_instr,
  output logic              f_err,
  input  logic              l_req,
  input  logic [31:0]       l_addr,
  input  logic [7:0]        l_data,
  output logic              l_gnt,
  output logic              m_re,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [7:0]        m_wdata,
  input  logic [31:0]       m_rdata,
  output logic              core_stall,
  output logic [ADDR_W:0]   load_count
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_CAP} state_t;

  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [31:0]     NOP     = 32'h0000_0013;

  state_t state, state_nx;
  logic   prog_q;
  logic   f_inrange, l_inrange;
  logic   unused_faddr_lsb;

  assign f_inrange        = (f_addr[31:ADDR_W] == '0);
  assign l_inrange        = (l_addr[31:ADDR_W] == '0);
  assign unused_faddr_lsb = ^f_addr[1:0];
  assign core_stall       = prog_mode | (state != IDLE);

  // Fetch wins in IDLE unless the loader owns memory; grants only from IDLE.
  always_comb begin
    state_nx = state;
    f_gnt    = 1'b0;
    l_gnt    = 1'b0;
    m_re     = 1'b0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    case (state)
      IDLE: begin
        if (f_req && !prog_mode) begin
          f_gnt = 1'b1;
          if (f_inrange) begin
            m_re     = 1'b1;
            m_addr   = {f_addr[ADDR_W-1:2], 2'b00};
            state_nx = RD_WAIT;
          end
        end else if (l_req) begin
          l_gnt = 1'b1;
          if (l_inrange) begin
            m_we    = 1'b1;
            m_addr  = l_addr[ADDR_W-1:0];
            m_wdata = l_data;
          end
        end
      end
      RD_WAIT: state_nx = RD_CAP;
      RD_CAP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      f_valid <= 1'b0;
      f_err   <= 1'b0;
      f_instr <= NOP;
      prog_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      f_valid <= (state == RD_CAP);
      f_err   <= f_gnt & ~f_inrange;
      prog_q  <= prog_mode;
      if (state == RD_CAP) f_instr <= m_rdata;
    end
  end

  // A write landing on the prog_mode rising edge counts as the first byte.
  logic [ADDR_W:0] cnt_base;
  assign cnt_base = (prog_mode && !prog_q) ? '0 : load_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      load_count <= '0;
    else if (m_we && cnt_base != CNT_MAX)
      load_count <= cnt_base + (ADDR_W+1)'(1);
    else
      load_count <= cnt_base;
  end

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Directed + randomized bench: behavioural RAM, byte-level scoreboard of
// expected memory contents and a simple count model of loaded bytes.
module tb_imem_access_arbiter;
  localparam int AW  = 11;
  localparam int MSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          prog_mode;
  logic          f_req;
  logic [31:0]   f_addr;
  logic          f_gnt, f_valid, f_err;
  logic [31:0]   f_instr;
  logic          l_req;
  logic [31:0]   l_addr;
  logic [7:0]    l_data;
  logic          l_gnt, m_re, m_we;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_wdata;
  logic [31:0]   m_rdata;
  logic          core_stall;
  logic [AW:0]   load_count;

  int total = 0;
  int bad   = 0;

  logic [7:0] ram     [0:MSZ-1];
  logic [7:0] exp_mem [0:MSZ-1];
  int         exp_cnt;

  imem_access_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .prog_mode(prog_mode),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid),
    .f_instr(f_instr), .f_err(f_err),
    .l_req(l_req), .l_addr(l_addr), .l_data(l_data), .l_gnt(l_gnt),
    .m_re(m_re), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .core_stall(core_stall), .load_count(load_count)
  );

  always #5 clk = ~clk;

  // Synchronous-read byte RAM, little-endian word reads.
  always @(posedge clk) begin
    if (m_we) ram[m_addr] <= m_wdata;
    if (m_re) m_rdata <= {ram[{m_addr[AW-1:2], 2'b11}], ram[{m_addr[AW-1:2], 2'b10}],
                          ram[{m_addr[AW-1:2], 2'b01}], ram[{m_addr[AW-1:2], 2'b00}]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    int w;
    w = int'(a[AW-1:0]) & ~3;
    return {exp_mem[w+3], exp_mem[w+2], exp_mem[w+1], exp_mem[w]};
  endfunction

  // Entered at cycle start with arbiter idle; leaves at cycle start.
  task automatic load_byte(input logic [31:0] a, input logic [7:0] d);
    logic inr;
    inr = (a < MSZ);
    l_req = 1'b1; l_addr = a; l_data = d;
    #4;
    chk("l_gnt", l_gnt, 1'b1);
    chk("m_we", m_we, inr);
    chk("m_re_on_load", m_re, 1'b0);
    if (inr) begin
      chk("m_addr_wr", m_addr, a[AW-1:0]);
      chk("m_wdata", m_wdata, d);
    end
    nxt();
    l_req = 1'b0;
    if (inr) begin
      exp_mem[a[AW-1:0]] = d;
      if (exp_cnt < MSZ) exp_cnt++;
    end
  endtask

  task automatic fetch(input logic [31:0] a);
    logic err;
    err = (a[31:AW] != '0);
    f_req = 1'b1; f_addr = a;
    #4;
    chk("f_gnt", f_gnt, 1'b1);
    chk("m_re", m_re, !err);
    chk("m_we_on_fetch", m_we, 1'b0);
    if (!err) chk("m_addr_rd", m_addr, {a[AW-1:2], 2'b00});
    nxt();
    f_req = 1'b0;
    #4;
    if (err) begin
      chk("f_err_pulse", f_err, 1'b1);
      chk("f_valid_on_err", f_valid, 1'b0);
      nxt(); #4;
      chk("f_err_clear", f_err, 1'b0);
      nxt();
    end else begin
      chk("f_valid_wait", f_valid, 1'b0);
      chk("stall_wait", core_stall, 1'b1);
      nxt(); #4;
      chk("f_valid_cap", f_valid, 1'b0);
      nxt(); #4;
      chk("f_valid", f_valid, 1'b1);
      chk("f_instr", f_instr, exp_word(a));
      chk("f_err_none", f_err, 1'b0);
      nxt();
    end
  endtask

  initial begin
    for (int i = 0; i < MSZ; i++) begin
      ram[i] = 8'h00;
      exp_mem[i] = 8'h00;
    end
    exp_cnt = 0;
    m_rdata = '0;
    rst = 1'b1; prog_mode = 1'b1;
    f_req = 1'b0; f_addr = '0; l_req = 1'b0; l_addr = '0; l_data = '0;
    #3;
    // reset values
    chk("rst_f_gnt", f_gnt, 1'b0);
    chk("rst_f_valid", f_valid, 1'b0);
    chk("rst_f_err", f_err, 1'b0);
    chk("rst_l_gnt", l_gnt, 1'b0);
    chk("rst_m_re", m_re, 1'b0);
    chk("rst_m_we", m_we, 1'b0);
    chk("rst_f_instr", f_instr, 32'h0000_0013);
    chk("rst_load_count", load_count, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_stall", core_stall, 1'b1);
    nxt();
    rst = 1'b0;

    // 1: program a NOP at address 0
    load_byte(0, 8'h13);
    load_byte(1, 8'h00);
    load_byte(2, 8'h00);
    load_byte(3, 8'h00);
    #4; chk("t1_count", load_count, 4); nxt();

    // 2: fetch with ignored low bits
    prog_mode = 1'b0;
    fetch(32'h2);

    // 3: simultaneous fetch and load; loader waits for the f_valid cycle
    f_req = 1'b1; f_addr = 32'h4;
    l_req = 1'b1; l_addr = 32'h8; l_data = 8'hA5;
    #4;
    chk("t3_f_gnt", f_gnt, 1'b1);
    chk("t3_l_gnt_blocked", l_gnt, 1'b0);
    nxt(); f_req = 1'b0; #4;
    chk("t3_l_gnt_wait", l_gnt, 1'b0);
    nxt(); #4;
    chk("t3_l_gnt_cap", l_gnt, 1'b0);
    nxt(); #4;
    chk("t3_f_valid", f_valid, 1'b1);
    chk("t3_f_instr", f_instr, exp_word(32'h4));
    chk("t3_l_gnt", l_gnt, 1'b1);
    chk("t3_m_we", m_we, 1'b1);
    chk("t3_m_addr", m_addr, 11'h8);
    nxt(); l_req = 1'b0;
    exp_mem[8] = 8'hA5; exp_cnt++;
    #4; chk("t3_count", load_count, exp_cnt); nxt();

    // 4: out-of-range fetch
    fetch(32'h800);

    // 5: fetch ignored while programming; out-of-range load
    prog_mode = 1'b1; f_req = 1'b1; f_addr = 32'h4;
    exp_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      #4;
      chk("t5_no_f_gnt", f_gnt, 1'b0);
      chk("t5_stall", core_stall, 1'b1);
      nxt();
    end
    f_req = 1'b0;
    #4; chk("t5_count_cleared", load_count, exp_cnt); nxt();
    load_byte(32'h900, 8'h5A);
    #4; chk("t5_count_same", load_count, exp_cnt); nxt();

    // random programming session then random fetches
    prog_mode = 1'b0; nxt();
    prog_mode = 1'b1; exp_cnt = 0; nxt();
    for (int i = 0; i < 60; i++)
      load_byte($urandom_range(0, MSZ + 255), 8'($urandom));
    #4; chk("rand_count", load_count, exp_cnt); nxt();
    prog_mode = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 5) == 0) fetch($urandom | 32'h0001_0000);
      else fetch($urandom_range(0, MSZ - 1));
    end

    // saturation of load_count
    prog_mode = 1'b1; exp_cnt = 0; nxt();
    for (int i = 0; i <= MSZ; i++)
      load_byte(i % MSZ, 8'(i));
    #4; chk("sat_count", load_count, exp_cnt); chk("sat_max", load_count, MSZ); nxt();

    // 6: reset during RD_WAIT drops the fetch
    prog_mode = 1'b0; f_req = 1'b1; f_addr = 32'h10;
    #4; chk("t6_f_gnt", f_gnt, 1'b1);
    nxt(); f_req = 1'b0; rst = 1'b1; #4;
    chk("t6_f_valid", f_valid, 1'b0);
    chk("t6_m_re", m_re, 1'b0);
    chk("t6_m_we", m_we, 1'b0);
    chk("t6_f_err", f_err, 1'b0);
    chk("t6_f_instr", f_instr, 32'h0000_0013);
    chk("t6_count", load_count, 0);
    chk("t6_stall", core_stall, 1'b0);
    chk("t6_m_addr", m_addr, 0);
    nxt(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #4; chk("t6_no_valid", f_valid, 1'b0); nxt();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
